uart_rx_engine: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_rx_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling ratio and the baud divider
// rounding used by both the receive and transmit engines.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

    // Ticks counted inside a bit: mid start bit is the 8th tick, a full bit is 16.
    localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    // Clocks per 16x tick, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int bit_rate);
        return (clk_hz + bit_rate * (OVERSAMPLE / 2)) / (bit_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x baud tick generator; restart re-phases the divider so the next
// tick lands exactly DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_engine.sv
// 8N1 UART receiver: 2-flop input synchronizer, 16x oversampling deframer and a
// byte holding register with avail/ack handshake and sticky error flag.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int freq_hz = 25000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error
);

    localparam int DIV = uart_div(freq_hz, baud);

    logic [1:0]     sync_q;
    logic           rxd_s;
    logic           tick;
    logic           restart;
    logic           commit;
    logic           frame_err;

    uart_rx_state_e state_q,   state_d;
    logic [3:0]     sample_q,  sample_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q,   shift_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_avail_q, rx_avail_d;
    logic           rx_error_q, rx_error_d;

    // Synchronizer resets to ones so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rxd};
        end
    end

    assign rxd_s = sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        sample_d  = sample_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        restart   = 1'b0;
        commit    = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d  = START;
                    sample_d = 4'd0;
                    restart  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == MID_SAMPLE) begin
                        sample_d = 4'd0;
                        if (rxd_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            bit_idx_d = 3'd0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == LAST_SAMPLE) begin
                        shift_d   = {rxd_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sample_d = sample_q + 4'd1;
                    if (sample_q == LAST_SAMPLE) begin
                        if (rxd_s) begin
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = BREAK;
                        end
                    end
                end
            end
            BREAK: begin
                if (tick && rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ack clears first, then a new byte or error overrides it in the same clock.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_avail_d = rx_avail_q;
        rx_error_d = rx_error_q;
        if (rx_ack) begin
            rx_avail_d = 1'b0;
            rx_error_d = 1'b0;
        end
        if (commit) begin
            rx_data_d  = shift_q;
            rx_avail_d = 1'b1;
            if (rx_avail_q && !rx_ack) begin
                rx_error_d = 1'b1;
            end
        end
        if (frame_err) begin
            rx_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sample_q   <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_avail_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_avail_q <= rx_avail_d;
            rx_error_q <= rx_error_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_avail = rx_avail_q;
    assign rx_error = rx_error_q;

endmodule
